// File: rtl/add_serial_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
package add_serial_pkg;

    // Smallest operand width the serial datapath supports.
    localparam int MIN_WIDTH = 2;

    // Operation sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width: enough to count 0 .. w-1.
    function automatic int cnt_width(input int w);
        return (w < MIN_WIDTH) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/add_serial_nb_fa_cell.sv
// Purely combinational 1-bit full adder; the single arithmetic slice of the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and majority carry of the three input bits.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/add_serial_nb.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock through one fa_cell.
// Optional macro ADD_SERIAL_OVF_EN adds the signed-overflow output V.
import add_serial_pkg::*;

module add_serial_nb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             Sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef ADD_SERIAL_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
`ifdef ADD_SERIAL_OVF_EN
    logic               v_q, v_d;
`endif

    logic               fa_s;
    logic               fa_co;
    logic               accept;
    logic               last_bit;

    // The one full-adder slice always sees the current LSBs and the running carry.
    fa_cell u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // A start is only honoured outside RUN; the last bit is when the counter hits WIDTH-1.
    assign accept   = start && (state_q != RUN);
    assign last_bit = (state_q == RUN) && (cnt_q == LAST_BIT);

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef ADD_SERIAL_OVF_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef ADD_SERIAL_OVF_EN
            v_q     <= v_d;
`endif
        end
    end

    // Next-state sequencing: IDLE -> RUN for WIDTH cycles -> DONE for one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: capture on accept, shift one bit per RUN cycle, latch flags on the last bit.
    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef ADD_SERIAL_OVF_EN
        v_d     = v_q;
`endif
        if (accept) begin
            // Subtraction is A + ~B + 1, so the inverted B and a forced carry are loaded up front.
            a_d     = A;
            b_d     = Sub ? ~B : B;
            carry_d = Sub ? 1'b1 : Ci;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            s_d     = {fa_s, s_q[WIDTH-1:1]};
            carry_d = fa_co;
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_bit) begin
                cout_d = fa_co;
`ifdef ADD_SERIAL_OVF_EN
                // Carry into the MSB is the running carry at this point.
                v_d    = fa_co ^ carry_q;
`endif
            end
        end
    end

    // Status and result outputs decoded from state and registers.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        S    = s_q;
        Cout = cout_q;
`ifdef ADD_SERIAL_OVF_EN
        V    = v_q;
`endif
    end

endmodule

// File: doc/add_serial_nb.md
Name: add_serial_nb

Overview:
Parametrised bit-serial N-bit adder/subtractor, the multi-bit sequential successor of the team's 1-bit full-adder cell. It accepts operands on a start strobe and processes one bit per clock, LSB first, through a single full-adder cell. It presents the sum, carry-out and a done pulse after WIDTH cycles. It is used where area matters more than latency, for example in lab datapaths and accumulators.

Parameters:
WIDTH, 8, operand and result width in bits; legal values are WIDTH >= 2.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous and active-high; clears all state immediately.
start  input  1  one-cycle request; captures A, B, Ci and Sub when accepted.
A  input  WIDTH  operand A (unsigned or two's complement).
B  input  WIDTH  operand B.
Ci  input  1  carry-in for add mode; ignored in subtract mode.
Sub  input  1  0 = A+B+Ci, 1 = A-B (computed as A + ~B + 1).
busy  output  1  high while the operation is in progress (RUN state).
done  output  1  one-cycle pulse when S and Cout become valid.
S  output  WIDTH  result; held stable from done until the next accepted start.
Cout  output  1  final carry; in subtract mode, 1 = no borrow (A >= B unsigned).
V  output  1  signed overflow; present only with ADD_SERIAL_OVF_EN.

Behaviour:
- Reset (asynchronous, rst=1):
  - state becomes IDLE, and the bit counter, carry flip-flop and operand shift registers are cleared.
  - outputs: S=0, Cout=0, busy=0, done=0, V=0.
- States:
  - IDLE: waits for start.
  - RUN: processes one bit per cycle.
  - DONE: asserts done for one cycle.
- Transitions:
  - IDLE or DONE, start=1: latch A, B (inverted if Sub=1), and carry (Ci if Sub=0, else 1). Clear the counter and go to RUN.
  - IDLE, start=0: stay in IDLE.
  - RUN, each edge: sum the LSB of both shift registers with the carry flip-flop in the full-adder cell. Shift the sum bit into the MSB of the result register, update the carry, shift both operands right by one, and increment the counter.
  - RUN, edge on which the counter equals WIDTH-1: load Cout from the adder carry and go to DONE.
  - DONE, start=0: go to IDLE.
- Latency: with start accepted on edge k, done=1 during the cycle following edge k+WIDTH. S is assembled in place and Cout/V update at edge k+WIDTH.
- busy=1 exactly during RUN (WIDTH cycles); done=1 only in DONE.
- start while in RUN is ignored: no re-capture and no effect on the running operation.
- start during the DONE cycle is accepted, giving back-to-back operations with one done cycle between them.
- S may change during RUN as bits shift in; consumers sample only on done or afterwards.
- Width rule: counter width is $clog2(WIDTH). Arithmetic is modulo 2^WIDTH, with the carry out of the MSB reported on Cout.
- Reset asserted mid-RUN aborts the operation: no done pulse, and all outputs take their reset values.

Optional Feature:
ADD_SERIAL_OVF_EN
- Defined: adds output V. At the final bit, V = carry into MSB XOR carry out of MSB, latched together with Cout and held like S. Reset value is 0.
- Undefined: port V and its flip-flop are absent; all other behaviour is identical.

Decomposition:
- Package add_serial_pkg holds:
  - the state enumeration typedef (IDLE, RUN, DONE);
  - localparam helpers for the counter width.
- One natural sub-module, fa_cell: a purely combinational 1-bit full adder (a, b, ci -> s, co), instantiated once for the bit slice.

Test Plan:
- WIDTH=8, A=8'h5A, B=8'h3C, Ci=0, Sub=0 -> S=8'h96, Cout=0; done exactly 8 cycles after start; busy high 8 cycles.
- A=8'hFF, B=8'h01, Ci=0 -> S=8'h00, Cout=1. Repeat with A=8'h00, B=8'h00, Ci=1 -> S=8'h01, Cout=0.
- Sub=1:
  - A=8'h20, B=8'h10 -> S=8'h10, Cout=1.
  - A=8'h10, B=8'h20 -> S=8'hF0, Cout=0.
  - Ci toggled has no effect in either case.
- Handshake:
  - start pulsed again 3 cycles into RUN -> ignored; first result is unchanged.
  - start in the DONE cycle -> second operation is accepted and its done follows 8 cycles later.
- rst asserted at cycle 4 of RUN -> busy, done, S and Cout go to 0 immediately with no done pulse; the next start works normally.
- With ADD_SERIAL_OVF_EN:
  - A=8'h7F, B=8'h01 add -> V=1, S=8'h80.
  - A=8'h80, B=8'h01 sub -> V=1, S=8'h7F.
  - A=8'h05, B=8'h03 add -> V=0.
